// File: rtl/rotate_pkg.sv
// rtl/rotate_pkg.sv - mode encodings and FSM states for the rotate/shift engine
package rotate_pkg;

    localparam logic [1:0] ROT = 2'b00;
    localparam logic [1:0] LSH = 2'b01;
    localparam logic [1:0] ASH = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rotate_step.sv
// rtl/rotate_step.sv - combinational single-pass mover, 0..STEP positions per pass
module rotate_step
    import rotate_pkg::*;
#(
    parameter int WIDTH = 100,
    parameter int STEP  = 1,
    parameter int K_W   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [K_W-1:0]   k,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] moved
);

    logic [2*WIDTH-1:0]      dbl;
    logic [2*WIDTH-1:0]      dbl_r;
    logic [2*WIDTH-1:0]      dbl_l;
    logic signed [WIDTH-1:0] sra;

    // Rotation uses a doubled copy so the bits leaving one end re-enter at the other;
    // the reserved mode code falls through to rotate.
    always_comb begin
        dbl   = {value, value};
        dbl_r = dbl >> k;
        dbl_l = dbl << k;
        sra   = $signed(value) >>> k;
        case (mode)
            LSH:     moved = dir ? (value << k) : (value >> k);
            ASH:     moved = dir ? (value << k) : sra;
            default: moved = dir ? dbl_l[2*WIDTH-1:WIDTH] : dbl_r[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/rotate_shift_engine.sv
// rtl/rotate_shift_engine.sv - multi-cycle rotate/shift register with legacy single-step rotate
module rotate_shift_engine
    import rotate_pkg::*;
#(
    parameter int WIDTH = 100,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       ena,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam int               K_W    = $clog2(STEP + 1);
    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    state_t           state, state_nx;
    logic [AMT_W-1:0] remaining, rem_nx;
    logic             cap_dir, cap_dir_nx;
    logic [1:0]       cap_mode, cap_mode_nx;
    logic [WIDTH-1:0] q_nx;
    logic             done_nx;

    logic [AMT_W-1:0] run_k;
    logic [K_W-1:0]   step_k;
    logic             step_dir;
    logic [1:0]       step_mode;
    logic [WIDTH-1:0] moved;

    assign run_k = (remaining < STEP_A) ? remaining : STEP_A;
    assign busy  = (state == RUN);

    // The single mover serves the commanded operation in RUN and the legacy one-bit rotate in IDLE.
    always_comb begin
        step_k    = run_k[K_W-1:0];
        step_dir  = cap_dir;
        step_mode = cap_mode;
        if (state == IDLE) begin
            step_k    = K_W'(1);
            step_dir  = ena[1];
            step_mode = ROT;
        end
    end

    rotate_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .K_W   (K_W)
    ) u_step (
        .value (q),
        .k     (step_k),
        .dir   (step_dir),
        .mode  (step_mode),
        .moved (moved)
    );

    // Next-state logic in priority order: load, start, RUN step, legacy ena.
    always_comb begin
        state_nx    = state;
        rem_nx      = remaining;
        cap_dir_nx  = cap_dir;
        cap_mode_nx = cap_mode;
        q_nx        = q;
        done_nx     = 1'b0;
        if (load) begin
            q_nx     = data;
            state_nx = IDLE;
            rem_nx   = '0;
        end else if (state == IDLE && start) begin
            cap_dir_nx  = dir;
            cap_mode_nx = mode;
            rem_nx      = amount;
            state_nx    = RUN;
        end else if (state == RUN) begin
            q_nx   = moved;
            rem_nx = remaining - run_k;
            if (remaining == run_k) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
        end else if (ena == 2'b01 || ena == 2'b10) begin
            q_nx = moved;
        end
    end

    // State, counter, captured command and data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            cap_dir   <= 1'b0;
            cap_mode  <= 2'b00;
            q         <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= rem_nx;
            cap_dir   <= cap_dir_nx;
            cap_mode  <= cap_mode_nx;
            q         <= q_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_rotate_shift_engine.sv
// tb/tb_rotate_shift_engine.sv - randomized and directed bench for STEP=1 and STEP=3 engines
module tb_rotate_shift_engine;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n, load, start, dir;
    logic [1:0]    mode, ena;
    logic [W-1:0]  data;
    logic [AW-1:0] amount;
    logic [W-1:0]  q1, q3;
    logic          busy1, busy3, done1, done3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rotate_shift_engine #(.WIDTH(W), .STEP(1), .AMT_W(AW)) u_s1 (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .start(start), .dir(dir),
        .mode(mode), .amount(amount), .ena(ena), .q(q1), .busy(busy1), .done(done1)
    );

    rotate_shift_engine #(.WIDTH(W), .STEP(3), .AMT_W(AW)) u_s3 (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .start(start), .dir(dir),
        .mode(mode), .amount(amount), .ena(ena), .q(q3), .busy(busy3), .done(done3)
    );

    // Whole-operation result computed directly from the amount.
    function automatic logic [7:0] model(input logic [7:0] v, input logic d, input logic [1:0] m, input int n);
        logic [7:0]        r;
        logic signed [7:0] s;
        int                rr;
        s = v;
        if (m == 2'b01 || (m == 2'b10 && d)) begin
            if (n >= 8) r = 8'h00;
            else if (d) r = v << n;
            else r = v >> n;
        end else if (m == 2'b10) begin
            if (n >= 8) r = {8{v[7]}};
            else r = s >>> n;
        end else begin
            rr = n % 8;
            if (rr == 0) r = v;
            else if (d) r = (v << rr) | (v >> (8 - rr));
            else r = (v >> rr) | (v << (8 - rr));
        end
        return r;
    endfunction

    function automatic int latency(input int n, input int step);
        return (n == 0) ? 1 : (n + step - 1) / step;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        data = v;
        cyc();
        load = 1'b0;
    endtask

    task automatic run_op(input logic d, input logic [1:0] m, input int amt,
                          output int nb1, output int nb3, output int nd1, output int nd3,
                          output logic [7:0] qd1, output logic [7:0] qd3, output int ovl);
        int extra;
        nb1 = 0; nb3 = 0; nd1 = 0; nd3 = 0; ovl = 0; extra = 0;
        qd1 = 8'h00; qd3 = 8'h00;
        dir = d; mode = m; amount = AW'(amt); start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy1) nb1++;
            if (busy3) nb3++;
            if (done1) begin nd1++; qd1 = q1; end
            if (done3) begin nd3++; qd3 = q3; end
            if ((busy1 && done1) || (busy3 && done3)) ovl++;
            if (nd1 > 0 && nd3 > 0 && !busy1 && !busy3) begin
                extra++;
                if (extra > 2) break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; start = 1'b0; dir = 1'b0; mode = 2'b00; ena = 2'b00;
        data = 8'h00; amount = '0;
        cyc(); cyc();
        checks++; if (q1 !== 8'h00 || q3 !== 8'h00) begin errors++; $display("FAIL reset_q: got %h/%h expected 00", q1, q3); end
        checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0 || done1 !== 1'b0 || done3 !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy %b/%b done %b/%b expected 0", busy1, busy3, done1, done3); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_rotate_right();
        int nb1, nb3, nd1, nd3, ovl; logic [7:0] qd1, qd3;
        do_load(8'hB1);
        run_op(1'b0, 2'b00, 3, nb1, nb3, nd1, nd3, qd1, qd3, ovl);
        checks++; if (nb1 !== 3) begin errors++; $display("FAIL rotr_busy_s1: got %0d expected 3", nb1); end
        checks++; if (nd1 !== 1 || qd1 !== 8'h36) begin errors++; $display("FAIL rotr_done_s1: got %0d pulses q=%h expected 1 q=36", nd1, qd1); end
        checks++; if (nb3 !== 1 || qd3 !== 8'h36) begin errors++; $display("FAIL rotr_s3: got busy %0d q=%h expected 1 q=36", nb3, qd3); end
        checks++; if (ovl !== 0) begin errors++; $display("FAIL rotr_overlap: got %0d expected 0", ovl); end
    endtask

    task automatic test_rotate_left_step3();
        int nb1, nb3, nd1, nd3, ovl; logic [7:0] qd1, qd3;
        do_load(8'h01);
        run_op(1'b1, 2'b00, 7, nb1, nb3, nd1, nd3, qd1, qd3, ovl);
        checks++; if (nb3 !== 3) begin errors++; $display("FAIL rotl_busy_s3: got %0d expected 3", nb3); end
        checks++; if (nd3 !== 1 || qd3 !== 8'h80) begin errors++; $display("FAIL rotl_done_s3: got %0d pulses q=%h expected 1 q=80", nd3, qd3); end
        checks++; if (nb1 !== 7 || qd1 !== 8'h80) begin errors++; $display("FAIL rotl_s1: got busy %0d q=%h expected 7 q=80", nb1, qd1); end
    endtask

    task automatic test_shifts();
        int nb1, nb3, nd1, nd3, ovl; logic [7:0] qd1, qd3;
        do_load(8'h90);
        run_op(1'b0, 2'b10, 2, nb1, nb3, nd1, nd3, qd1, qd3, ovl);
        checks++; if (qd1 !== 8'hE4 || qd3 !== 8'hE4) begin errors++; $display("FAIL ash_right: got %h/%h expected e4", qd1, qd3); end
        do_load(8'h90);
        run_op(1'b0, 2'b01, 2, nb1, nb3, nd1, nd3, qd1, qd3, ovl);
        checks++; if (qd1 !== 8'h24 || qd3 !== 8'h24) begin errors++; $display("FAIL lsh_right: got %h/%h expected 24", qd1, qd3); end
        do_load(8'hFF);
        run_op(1'b0, 2'b01, 9, nb1, nb3, nd1, nd3, qd1, qd3, ovl);
        checks++; if (qd1 !== 8'h00 || qd3 !== 8'h00 || nd1 !== 1 || nd3 !== 1) begin
            errors++; $display("FAIL lsh_over_width: got %h/%h pulses %0d/%0d expected 00 with 1 pulse", qd1, qd3, nd1, nd3); end
    endtask

    task automatic test_zero_amount();
        int nb1, nb3, nd1, nd3, ovl; logic [7:0] qd1, qd3;
        do_load(8'hC3);
        run_op(1'b1, 2'b00, 0, nb1, nb3, nd1, nd3, qd1, qd3, ovl);
        checks++; if (nb1 !== 1 || nb3 !== 1) begin errors++; $display("FAIL zero_busy: got %0d/%0d expected 1", nb1, nb3); end
        checks++; if (nd1 !== 1 || nd3 !== 1 || qd1 !== 8'hC3 || qd3 !== 8'hC3) begin
            errors++; $display("FAIL zero_done: got pulses %0d/%0d q=%h/%h expected 1 q=c3", nd1, nd3, qd1, qd3); end
    endtask

    task automatic test_abort();
        int nd;
        do_load(8'h11);
        dir = 1'b0; mode = 2'b00; amount = AW'(5); start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        load = 1'b1; data = 8'h5A;
        cyc();
        load = 1'b0;
        checks++; if (q1 !== 8'h5A || q3 !== 8'h5A || busy1 !== 1'b0 || busy3 !== 1'b0) begin
            errors++; $display("FAIL abort_load: got q=%h/%h busy=%b/%b expected 5a busy 0", q1, q3, busy1, busy3); end
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (done1 || done3 || busy1 || busy3) nd++;
            cyc();
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", nd); end
    endtask

    task automatic test_legacy();
        int n;
        do_load(8'h81);
        ena = 2'b10;
        cyc();
        ena = 2'b00;
        checks++; if (q1 !== 8'h03 || q3 !== 8'h03) begin errors++; $display("FAIL ena_left: got %h/%h expected 03", q1, q3); end
        ena = 2'b01;
        cyc();
        ena = 2'b00;
        checks++; if (q1 !== 8'h81 || q3 !== 8'h81) begin errors++; $display("FAIL ena_right: got %h/%h expected 81", q1, q3); end
        ena = 2'b11;
        cyc();
        ena = 2'b00;
        checks++; if (q1 !== 8'h81) begin errors++; $display("FAIL ena_hold: got %h expected 81", q1); end
        ena = 2'b10; dir = 1'b0; mode = 2'b00; amount = AW'(4); start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        ena = 2'b00;
        n = 0;
        while ((busy1 || busy3) && n < 50) begin cyc(); n++; end
        checks++; if (q1 !== 8'h18 || q3 !== 8'h18 || n >= 50) begin
            errors++; $display("FAIL ena_in_run: got %h/%h expected 18", q1, q3); end
    endtask

    task automatic test_reset_mid_run();
        int act;
        do_load(8'hA5);
        dir = 1'b1; mode = 2'b00; amount = AW'(6); start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        checks++; if (q1 !== 8'h00 || q3 !== 8'h00 || busy1 !== 1'b0 || busy3 !== 1'b0 || done1 !== 1'b0 || done3 !== 1'b0) begin
            errors++; $display("FAIL reset_mid_run: got q=%h/%h busy=%b/%b done=%b/%b expected all 0", q1, q3, busy1, busy3, done1, done3); end
        cyc();
        rst_n = 1'b1;
        act = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (done1 || done3 || busy1 || busy3) act++;
        end
        checks++; if (act !== 0) begin errors++; $display("FAIL reset_no_resume: got %0d active cycles expected 0", act); end
    endtask

    task automatic test_random();
        int nb1, nb3, nd1, nd3, ovl, amt; logic [7:0] qd1, qd3, v, exp_q;
        logic d; logic [1:0] m;
        for (int t = 0; t < 24; t++) begin
            v   = 8'($urandom);
            d   = 1'($urandom);
            m   = 2'($urandom);
            amt = int'($urandom_range(0, 15));
            do_load(v);
            run_op(d, m, amt, nb1, nb3, nd1, nd3, qd1, qd3, ovl);
            exp_q = model(v, d, m, amt);
            checks++; if (qd1 !== exp_q || qd3 !== exp_q) begin
                errors++; $display("FAIL rand_q[%0d]: v=%h d=%b m=%b n=%0d got %h/%h expected %h", t, v, d, m, amt, qd1, qd3, exp_q); end
            checks++; if (nb1 !== latency(amt, 1) || nb3 !== latency(amt, 3)) begin
                errors++; $display("FAIL rand_busy[%0d]: n=%0d got %0d/%0d expected %0d/%0d", t, amt, nb1, nb3, latency(amt, 1), latency(amt, 3)); end
            checks++; if (nd1 !== 1 || nd3 !== 1 || ovl !== 0) begin
                errors++; $display("FAIL rand_done[%0d]: got pulses %0d/%0d overlap %0d expected 1/1 overlap 0", t, nd1, nd3, ovl); end
            checks++; if (q1 !== exp_q || q3 !== exp_q) begin
                errors++; $display("FAIL rand_hold[%0d]: got %h/%h expected %h", t, q1, q3, exp_q); end
        end
    endtask

    initial begin
        test_reset();
        test_rotate_right();
        test_rotate_left_step3();
        test_shifts();
        test_zero_amount();
        test_abort();
        test_legacy();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
